// File: rtl/llc_mshr_table_pkg.sv
// Shared MSHR types and sizing constants for the Spandex LLC MSHR table
// (entry states, entry payload, table and field widths).
package llc_mshr_table_pkg;

  localparam int N_MSHR       = 4;
  localparam int MSHR_BITS_P1 = 3;
  localparam int LLC_SET_BITS = 8;
  localparam int LLC_TAG_BITS = 8;
  localparam int LLC_WAY_BITS = 4;
  localparam int IDX_BITS     = $clog2(N_MSHR);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2,
    RTR  = 2'd3
  } mshr_state_t;

  typedef struct packed {
    logic [LLC_SET_BITS-1:0] set;
    logic [LLC_TAG_BITS-1:0] tag;
    logic [LLC_WAY_BITS-1:0] way;
  } llc_mshr_entry_t;

endpackage

// File: rtl/llc_mshr_table_if.sv
// Controller <-> MSHR table bus: alloc, lookup, memory response, retire and
// credit-counter pulses. The table side uses the slave modport.
interface llc_mshr_if;
  import llc_mshr_table_pkg::*;

  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [LLC_SET_BITS-1:0] alloc_set;
  logic [LLC_TAG_BITS-1:0] alloc_tag;
  logic [LLC_WAY_BITS-1:0] alloc_way;
  logic [IDX_BITS-1:0]     alloc_idx;

  logic [LLC_SET_BITS-1:0] lookup_set;
  logic [LLC_TAG_BITS-1:0] lookup_tag;
  logic                    lookup_set_hit;
  logic                    lookup_tag_hit;
  logic [IDX_BITS-1:0]     lookup_idx;

  logic                    mem_rsp_valid;
  logic [IDX_BITS-1:0]     mem_rsp_idx;

  logic                    retire_valid;
  logic                    retire_ready;
  logic [IDX_BITS-1:0]     retire_idx;
  logic [LLC_SET_BITS-1:0] retire_set;
  logic [LLC_TAG_BITS-1:0] retire_tag;
  logic [LLC_WAY_BITS-1:0] retire_way;

  logic                    add_mshr_entry;
  logic                    incr_mshr_cnt;
  logic [MSHR_BITS_P1-1:0] free_cnt;

  modport master (
    output alloc_valid, alloc_set, alloc_tag, alloc_way,
    output lookup_set, lookup_tag,
    output mem_rsp_valid, mem_rsp_idx,
    output retire_ready,
    input  alloc_ready, alloc_idx,
    input  lookup_set_hit, lookup_tag_hit, lookup_idx,
    input  retire_valid, retire_idx, retire_set, retire_tag, retire_way,
    input  add_mshr_entry, incr_mshr_cnt, free_cnt
  );

  modport slave (
    input  alloc_valid, alloc_set, alloc_tag, alloc_way,
    input  lookup_set, lookup_tag,
    input  mem_rsp_valid, mem_rsp_idx,
    input  retire_ready,
    output alloc_ready, alloc_idx,
    output lookup_set_hit, lookup_tag_hit, lookup_idx,
    output retire_valid, retire_idx, retire_set, retire_tag, retire_way,
    output add_mshr_entry, incr_mshr_cnt, free_cnt
  );

endinterface

// File: rtl/llc_mshr_table_prio_enc.sv
// Lowest-index priority encoder; idx is 0 when no bit is set.
module llc_mshr_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/llc_mshr_table.sv
// Spandex LLC MSHR entry table with registered retire stage.
// Optional LLC_MSHR_CHECK_EN adds the sticky rsp_err protocol-error output.
module llc_mshr_table
  import llc_mshr_table_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  llc_mshr_if.slave      bus
`ifdef LLC_MSHR_CHECK_EN
  ,
  output logic           rsp_err
`endif
);

  mshr_state_t             state_q [N_MSHR];
  mshr_state_t             state_d [N_MSHR];
  llc_mshr_entry_t         entry_q [N_MSHR];

  logic [N_MSHR-1:0]       free_vec, resp_vec, set_vec, match_vec;
  logic [IDX_BITS-1:0]     free_idx, resp_idx, match_idx;
  logic                    free_any, resp_any, match_any;
  logic                    alloc_fire, retire_fire, load;

  logic [MSHR_BITS_P1-1:0] free_cnt_q;
  logic                    retire_valid_q;
  logic [IDX_BITS-1:0]     retire_idx_q;
  llc_mshr_entry_t         retire_q;

  always_comb begin
    free_vec  = '0;
    resp_vec  = '0;
    set_vec   = '0;
    match_vec = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      free_vec[i]  = (state_q[i] == FREE);
      resp_vec[i]  = (state_q[i] == RESP);
      set_vec[i]   = (state_q[i] != FREE) && (entry_q[i].set == bus.lookup_set);
      match_vec[i] = set_vec[i] && (entry_q[i].tag == bus.lookup_tag);
    end
  end

  llc_mshr_prio_enc #(.N(N_MSHR), .IDX_W(IDX_BITS)) u_free_enc (
    .vec(free_vec), .idx(free_idx), .any(free_any)
  );

  llc_mshr_prio_enc #(.N(N_MSHR), .IDX_W(IDX_BITS)) u_resp_enc (
    .vec(resp_vec), .idx(resp_idx), .any(resp_any)
  );

  llc_mshr_prio_enc #(.N(N_MSHR), .IDX_W(IDX_BITS)) u_match_enc (
    .vec(match_vec), .idx(match_idx), .any(match_any)
  );

  // Blocking alloc during a retire handshake keeps the two credit pulses exclusive.
  assign retire_fire = retire_valid_q && bus.retire_ready;
  assign bus.alloc_ready = free_any && (free_cnt_q != '0) && !retire_fire;
  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
  assign load        = resp_any && (!retire_valid_q || retire_fire);

  always_comb begin
    for (int i = 0; i < N_MSHR; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        FREE: if (alloc_fire && free_idx == IDX_BITS'(i)) state_d[i] = PEND;
        PEND: if (bus.mem_rsp_valid && bus.mem_rsp_idx == IDX_BITS'(i)) state_d[i] = RESP;
        RESP: if (load && resp_idx == IDX_BITS'(i)) state_d[i] = RTR;
        RTR:  if (retire_fire && retire_idx_q == IDX_BITS'(i)) state_d[i] = FREE;
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MSHR; i++) begin
        state_q[i] <= FREE;
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_MSHR; i++) state_q[i] <= state_d[i];
      if (alloc_fire) begin
        entry_q[free_idx] <= '{set: bus.alloc_set, tag: bus.alloc_tag, way: bus.alloc_way};
      end
    end
  end

  // Retire stage: fields only change on load, so they hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_valid_q <= 1'b0;
      retire_idx_q   <= '0;
      retire_q       <= '0;
    end else if (load) begin
      retire_valid_q <= 1'b1;
      retire_idx_q   <= resp_idx;
      retire_q       <= entry_q[resp_idx];
    end else if (retire_fire) begin
      retire_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_cnt_q <= MSHR_BITS_P1'(N_MSHR);
    end else if (alloc_fire) begin
      free_cnt_q <= free_cnt_q - MSHR_BITS_P1'(1);
    end else if (retire_fire) begin
      free_cnt_q <= free_cnt_q + MSHR_BITS_P1'(1);
    end
  end

`ifdef LLC_MSHR_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_err_q <= 1'b0;
    end else if ((bus.mem_rsp_valid && state_q[bus.mem_rsp_idx] != PEND) ||
                 (bus.retire_ready && !retire_valid_q)) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`endif

  assign bus.alloc_idx      = free_idx;
  assign bus.lookup_set_hit = |set_vec;
  assign bus.lookup_tag_hit = match_any;
  assign bus.lookup_idx     = match_idx;
  assign bus.retire_valid   = retire_valid_q;
  assign bus.retire_idx     = retire_idx_q;
  assign bus.retire_set     = retire_q.set;
  assign bus.retire_tag     = retire_q.tag;
  assign bus.retire_way     = retire_q.way;
  assign bus.add_mshr_entry = alloc_fire;
  assign bus.incr_mshr_cnt  = retire_fire;
  assign bus.free_cnt       = free_cnt_q;

endmodule
